coupler_2_to_4: RTL
===================

// Module: coupler_2_to_4
// PURPOSE
//  Output stage directly downstream of the 2-tuple merger. Accepts the merger's stream of
//  2-element tuples (one tuple per write) and packs consecutive pairs into 4-element words.
//  Packed words are buffered in a FWFT FIFO that feeds the next, wider merger level.
//  Handles the all-zero end-of-run marker and gives the merger a headroom-safe ready signal.
// PARAMETERS
//  DATA_WIDTH  128  width of one element; key is in the element's low bits
//  DEPTH       16   output FIFO depth in 4-element words; power of 2, >= 8
//  ADDR_WIDTH  4    log2(DEPTH)
// PORTS
//  i_clk       in   1             clock, rising edge
//  i_rst       in   1             synchronous reset, active high
//  i_data      in   2*DATA_WIDTH  input tuple {elem1, elem0}
//  i_write     in   1             i_data valid this cycle (merger's out-FIFO write)
//  o_ready     out  1             space available; merger registers it before use
//  i_deq       in   1             downstream pops the head word this cycle
//  o_data      out  4*DATA_WIDTH  head word {t1.elem1, t1.elem0, t0.elem1, t0.elem0}, FWFT
//  o_empty     out  1             FIFO holds no words
//  o_full      out  1             FIFO holds DEPTH words
//  o_count     out  ADDR_WIDTH+1  words in FIFO
//  o_overflow  out  1             sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (i_rst=1 at an edge): pack state EMPTY, holding reg 0, FIFO cleared, o_count=0,
//   o_empty=1, o_full=0, o_overflow=0, o_ready=1, o_data=0. Reset mid-packet discards the half word.
//  Pack FSM states: EMPTY (no tuple held), HALF (tuple t0 held), FLUSH (terminator owed).
//   EMPTY + write nonzero tuple   -> hold it as t0, go HALF; no FIFO write.
//   EMPTY + write all-zero tuple  -> enqueue all-zero word; stay EMPTY.
//   HALF  + write nonzero tuple t1 -> enqueue {t1, t0}; go EMPTY.
//   HALF  + write all-zero tuple  -> enqueue {0, t0} (pad); go FLUSH.
//   FLUSH -> enqueue all-zero word; if i_write the same cycle, handle i_data exactly as in EMPTY,
//     except that a zero tuple enqueues its own zero word next cycle (stay FLUSH); with no
//     write, go EMPTY. Input is never stalled in any state.
//   No i_write -> state and holding reg unchanged (except the FLUSH exit above).
//  Zero tuple = all 2*DATA_WIDTH bits 0. Packing never reorders; t0 always occupies the low half.
//  Enqueue latency: a word is enqueued on the edge that accepts its second tuple (or the terminator).
//   It is visible on o_data / !o_empty one cycle later.
//  FIFO: FWFT, at most 1 enqueue and 1 dequeue per cycle; both at once leaves count unchanged.
//   Dequeue with o_empty=1 is ignored. Enqueue with o_full=1 and no same-cycle dequeue drops
//   the word and sets o_overflow. Enqueue when full with a same-cycle dequeue is accepted.
//   Pointers wrap modulo DEPTH.
//  o_ready = (o_count <= DEPTH-4), combinational from registered count. Headroom of 3 words covers
//   the merger's registered ready (1-cycle lag) plus its pipeline write and one FLUSH word.
//   A correct upstream therefore never overflows.
// TESTING
//  1 Reset, DATA_WIDTH=8: write 0x0201, 0x0403 -> one word 0x04030201 after 1 cycle, o_count=1.
//  2 Write 0x0201, then 0x0000 -> words 0x00000201 then 0x00000000, state ends EMPTY.
//  3 FLUSH overlap: 0x0201, 0x0000, 0x0605 back-to-back, then 0x0807
//     -> words 0x00000201, 0x00000000, 0x08070605 in order.
//  4 Fill with i_deq=0: o_ready falls when o_count reaches DEPTH-3 (13 for DEPTH=16). Keep writing:
//     o_full=1 at 16 words, the next word is dropped and o_overflow=1 (sticky until reset).
//  5 Full FIFO with simultaneous enqueue+dequeue -> count stays 16, no overflow,
//     order preserved across pointer wrap.
//  6 Assert i_rst while in HALF holding 0x0201, then write 0x0403, 0x0605
//     -> only word 0x06050403 emerges; all outputs at reset values during reset.

Source files
------------

// File: rtl/coupler_2_to_4.sv
// Packs consecutive 2-element tuples into 4-element words and buffers them in a FWFT FIFO.
// All-zero tuples act as end-of-run markers: they pad any held half word and emit a zero word.
module coupler_2_to_4 #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [2*DATA_WIDTH-1:0]   i_data,
    input  logic                      i_write,
    output logic                      o_ready,
    input  logic                      i_deq,
    output logic [4*DATA_WIDTH-1:0]   o_data,
    output logic                      o_empty,
    output logic                      o_full,
    output logic [ADDR_WIDTH:0]       o_count,
    output logic                      o_overflow
);

    localparam int unsigned TupleWidth = 2 * DATA_WIDTH;
    localparam int unsigned WordWidth  = 4 * DATA_WIDTH;

    localparam logic [ADDR_WIDTH:0]   FullCount = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ReadyMax  = (ADDR_WIDTH + 1)'(DEPTH - 4);
    localparam logic [ADDR_WIDTH:0]   CountOne  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne    = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {StEmpty, StHalf, StFlush} state_e;

    state_e                state_q, state_d;
    logic [TupleWidth-1:0] hold_q, hold_d;
    logic                  tuple_zero;
    logic                  enq;
    logic [WordWidth-1:0]  enq_data;

    assign tuple_zero = (i_data == '0);

    // Pack FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StEmpty;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Pack FSM: next state
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StEmpty: begin
                if (i_write && !tuple_zero) begin
                    state_d = StHalf;
                    hold_d  = i_data;
                end
            end
            StHalf: begin
                if (i_write) state_d = tuple_zero ? StFlush : StEmpty;
            end
            StFlush: begin
                // A zero tuple here owes its own zero word, so FLUSH is re-entered.
                if (!i_write) begin
                    state_d = StEmpty;
                end else if (!tuple_zero) begin
                    state_d = StHalf;
                    hold_d  = i_data;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Pack FSM: enqueue request (a zero second tuple naturally yields the padded word)
    always_comb begin
        enq      = 1'b0;
        enq_data = '0;
        unique case (state_q)
            StEmpty: enq = i_write && tuple_zero;
            StHalf: begin
                enq      = i_write;
                enq_data = {i_data, hold_q};
            end
            StFlush: enq = 1'b1;
            default: enq = 1'b0;
        endcase
    end

    // Output FIFO
    logic [WordWidth-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  overflow_q;
    logic                  deq_ok, enq_ok, full;

    assign full   = (count_q == FullCount);
    assign deq_ok = i_deq && (count_q != '0);
    assign enq_ok = enq && (!full || deq_ok);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (deq_ok) rd_ptr_q <= rd_ptr_q + PtrOne;
            if (enq_ok && !deq_ok) begin
                count_q <= count_q + CountOne;
            end else if (!enq_ok && deq_ok) begin
                count_q <= count_q - CountOne;
            end
            if (enq && !enq_ok) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && enq_ok) mem[wr_ptr_q] <= enq_data;
    end

    assign o_data     = (count_q == '0) ? '0 : mem[rd_ptr_q];
    assign o_empty    = (count_q == '0);
    assign o_full     = full;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;
    // Three words of headroom cover the upstream's registered-ready lag and a FLUSH word.
    assign o_ready    = (count_q <= ReadyMax);

endmodule
